// File: rtl/conv1d_seq_pkg.sv
// Shared constants, CFU command codes and sequencer state encoding for the conv1d command sequencer.
package conv1d_seq_pkg;

    localparam int MAX_WIDTH     = 1024;
    localparam int MAX_DEPTH     = 128;
    localparam int KERNEL_LENGTH = 8;
    localparam int ORIGIN_OFFSET = 3;

    localparam logic [6:0] CMD_RESET      = 7'd0;
    localparam logic [6:0] CMD_WR_INPUT   = 7'd10;
    localparam logic [6:0] CMD_WR_KERNEL  = 7'd11;
    localparam logic [6:0] CMD_SET_OFFSET = 7'd20;
    localparam logic [6:0] CMD_SET_WIDTH  = 7'd25;
    localparam logic [6:0] CMD_SET_DEPTH  = 7'd26;
    localparam logic [6:0] CMD_SET_BIAS   = 7'd27;
    localparam logic [6:0] CMD_COMPUTE    = 7'd41;
    localparam logic [6:0] CMD_SET_ORIGIN = 7'd42;
    localparam logic [6:0] CMD_READ_ACC   = 7'd43;
    localparam logic [6:0] CMD_NOP        = 7'd127;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CLEAR,
        ST_PARAM,
        ST_LOAD_W,
        ST_LOAD_X,
        ST_ORIGIN,
        ST_COMPUTE,
        ST_FETCH,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/conv1d_cmd_sequencer_if.sv
// Control, byte-stream, result-stream and CFU command signals of the conv1d sequencer.
interface conv1d_cmd_sequencer_if;

    logic        start;
    logic [31:0] cfg_width;
    logic [31:0] cfg_depth;
    logic [31:0] cfg_input_offset;
    logic [31:0] cfg_bias;
    logic        busy;
    logic        done;
    logic        err;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [6:0]  cfu_cmd;
    logic [31:0] cfu_inp0;
    logic [31:0] cfu_inp1;
    logic [31:0] cfu_ret;

    modport master (
        input  start, cfg_width, cfg_depth, cfg_input_offset, cfg_bias,
        input  s_valid, s_data, m_ready, cfu_ret,
        output busy, done, err, s_ready, m_valid, m_data,
        output cfu_cmd, cfu_inp0, cfu_inp1
    );

    modport slave (
        output start, cfg_width, cfg_depth, cfg_input_offset, cfg_bias,
        output s_valid, s_data, m_ready, cfu_ret,
        input  busy, done, err, s_ready, m_valid, m_data,
        input  cfu_cmd, cfu_inp0, cfu_inp1
    );

endinterface

// File: rtl/conv1d_seq_cmd_reg.sv
// Registered CFU command driver: holds a requested command for exactly one cycle, NOP otherwise.
module conv1d_seq_cmd_reg
    import conv1d_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    input  logic [6:0]  cmd_d,
    input  logic [31:0] inp0_d,
    input  logic [31:0] inp1_d,
    output logic [6:0]  cmd,
    output logic [31:0] inp0,
    output logic [31:0] inp1
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd  <= CMD_NOP;
            inp0 <= '0;
            inp1 <= '0;
        end else if (issue) begin
            cmd  <= cmd_d;
            inp0 <= inp0_d;
            inp1 <= inp1_d;
        end else begin
            cmd  <= CMD_NOP;
            inp0 <= '0;
            inp1 <= '0;
        end
    end

endmodule

// File: rtl/conv1d_cmd_sequencer.sv
// Per-layer conv1d CFU driver: clear, parameters, kernel/input streaming, per-position compute and readback.
// Build option CONV1D_SEQ_RELU_EN clamps captured accumulators at zero.
module conv1d_cmd_sequencer
    import conv1d_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    conv1d_cmd_sequencer_if.master bus
);

    state_t      state;
    logic [31:0] width_q, depth_q, offset_q, bias_q;
    logic [16:0] idx;
    logic [10:0] out_x;
    logic [1:0]  param_idx;
    logic        busy_q, done_q, err_q, s_ready_q, m_valid_q;
    logic [31:0] m_data_q;

    logic        issue;
    logic [6:0]  cmd_d;
    logic [31:0] inp0_d, inp1_d;
    logic        beat;
    logic [17:0] kern_count, in_count;
    logic        cfg_ok;

    assign beat       = s_ready_q && bus.s_valid;
    assign kern_count = 18'(KERNEL_LENGTH) * {10'd0, depth_q[7:0]};
    assign in_count   = {7'd0, width_q[10:0]} * {10'd0, depth_q[7:0]};
    assign cfg_ok     = (width_q >= 32'd1) && (width_q <= 32'(MAX_WIDTH)) &&
                        (depth_q >= 32'd1) && (depth_q <= 32'(MAX_DEPTH));

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;

    // Requests are registered by the command driver, so the CFU sees them the cycle after the state.
    always_comb begin
        issue  = 1'b0;
        cmd_d  = CMD_NOP;
        inp0_d = '0;
        inp1_d = '0;
        case (state)
            ST_CLEAR: begin
                issue = 1'b1;
                cmd_d = CMD_RESET;
            end
            ST_PARAM: begin
                issue = 1'b1;
                case (param_idx)
                    2'd0:    begin cmd_d = CMD_SET_OFFSET; inp1_d = offset_q; end
                    2'd1:    begin cmd_d = CMD_SET_WIDTH;  inp1_d = width_q;  end
                    2'd2:    begin cmd_d = CMD_SET_DEPTH;  inp1_d = depth_q;  end
                    default: begin cmd_d = CMD_SET_BIAS;   inp1_d = bias_q;   end
                endcase
            end
            ST_LOAD_W, ST_LOAD_X: begin
                if (beat) begin
                    issue  = 1'b1;
                    cmd_d  = (state == ST_LOAD_W) ? CMD_WR_KERNEL : CMD_WR_INPUT;
                    inp0_d = {15'd0, idx};
                    inp1_d = {24'd0, bus.s_data};
                end
            end
            ST_ORIGIN: begin
                issue  = 1'b1;
                cmd_d  = CMD_SET_ORIGIN;
                inp1_d = {21'd0, out_x} - 32'(ORIGIN_OFFSET);
            end
            ST_COMPUTE: begin
                issue = 1'b1;
                cmd_d = CMD_COMPUTE;
            end
            ST_FETCH: begin
                issue = 1'b1;
                cmd_d = CMD_READ_ACC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            width_q   <= '0;
            depth_q   <= '0;
            offset_q  <= '0;
            bias_q    <= '0;
            idx       <= '0;
            out_x     <= '0;
            param_idx <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        width_q  <= bus.cfg_width;
                        depth_q  <= bus.cfg_depth;
                        offset_q <= bus.cfg_input_offset;
                        bias_q   <= bus.cfg_bias;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cfg_ok) begin
                        state <= ST_CLEAR;
                    end else begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_CLEAR: begin
                    param_idx <= '0;
                    state     <= ST_PARAM;
                end
                ST_PARAM: begin
                    param_idx <= param_idx + 2'd1;
                    if (param_idx == 2'd3) begin
                        idx       <= '0;
                        s_ready_q <= 1'b1;
                        state     <= ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (beat) begin
                        if ({1'b0, idx} == kern_count - 18'd1) begin
                            idx   <= '0;
                            state <= ST_LOAD_X;
                        end else begin
                            idx <= idx + 17'd1;
                        end
                    end
                end
                ST_LOAD_X: begin
                    if (beat) begin
                        if ({1'b0, idx} == in_count - 18'd1) begin
                            s_ready_q <= 1'b0;
                            out_x     <= '0;
                            state     <= ST_ORIGIN;
                        end else begin
                            idx <= idx + 17'd1;
                        end
                    end
                end
                ST_ORIGIN:  state <= ST_COMPUTE;
                ST_COMPUTE: state <= ST_FETCH;
                ST_FETCH:   state <= ST_CAPTURE;
                ST_CAPTURE: begin
`ifdef CONV1D_SEQ_RELU_EN
                    m_data_q <= bus.cfu_ret[31] ? 32'd0 : bus.cfu_ret;
`else
                    m_data_q <= bus.cfu_ret;
`endif
                    m_valid_q <= 1'b1;
                    state     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        if (out_x == width_q[10:0] - 11'd1) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            out_x <= out_x + 11'd1;
                            state <= ST_ORIGIN;
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    conv1d_seq_cmd_reg u_cmd_reg (
        .clk    (clk),
        .reset  (reset),
        .issue  (issue),
        .cmd_d  (cmd_d),
        .inp0_d (inp0_d),
        .inp1_d (inp1_d),
        .cmd    (bus.cfu_cmd),
        .inp0   (bus.cfu_inp0),
        .inp1   (bus.cfu_inp1)
    );

endmodule

// File: tb/tb_conv1d_cmd_sequencer.sv
// Scoreboard bench for conv1d_cmd_sequencer with a behavioural conv1d CFU attached to the command port.
module tb_conv1d_cmd_sequencer;

    logic clk;
    logic reset;

    conv1d_cmd_sequencer_if bus ();

    conv1d_cmd_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural CFU: kernel index k*depth+c, input index x*depth+c, taps outside [0,width) are zero padding.
    logic [7:0] kmem [0:1023];
    logic [7:0] xmem [0:1023];
    int cfu_offset = 0, cfu_width = 0, cfu_depth = 0, cfu_bias = 0, cfu_origin = 0, cfu_acc = 0;

    function automatic int conv_acc();
        int s;
        s = cfu_bias;
        for (int k = 0; k < 8; k++) begin
            int x;
            x = cfu_origin + k;
            if (x >= 0 && x < cfu_width)
                for (int c = 0; c < cfu_depth; c++)
                    s += int'($signed(kmem[k*cfu_depth+c])) *
                         (int'($signed(xmem[x*cfu_depth+c])) + cfu_offset);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        case (bus.cfu_cmd)
            7'd0:  cfu_acc <= 0;
            7'd10: xmem[bus.cfu_inp0[9:0]] <= bus.cfu_inp1[7:0];
            7'd11: kmem[bus.cfu_inp0[9:0]] <= bus.cfu_inp1[7:0];
            7'd20: cfu_offset <= bus.cfu_inp1;
            7'd25: cfu_width  <= bus.cfu_inp1;
            7'd26: cfu_depth  <= bus.cfu_inp1;
            7'd27: cfu_bias   <= bus.cfu_inp1;
            7'd42: cfu_origin <= bus.cfu_inp1;
            7'd41: cfu_acc    <= conv_acc();
            default: ;
        endcase
    end

    assign bus.cfu_ret = (bus.cfu_cmd == 7'd43) ? 32'(cfu_acc) : 32'd0;

    int         exp_q [$];
    int         hs_q  [$];
    logic [7:0] stim  [$];
    int         cyc_cnt   = 0;
    int         beats_cnt = 0;
    bit         bp_mode   = 1'b0;
    bit         held      = 1'b0;
    logic [31:0] held_data;

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (bus.s_valid && bus.s_ready) beats_cnt++;
        if (bus.m_valid && !bus.m_ready) begin
            if (held) chk("m_data_hold", int'(bus.m_data), int'(held_data));
            held      = 1'b1;
            held_data = bus.m_data;
        end else begin
            held = 1'b0;
        end
        if (bus.m_valid && bus.m_ready) begin
            hs_q.push_back(cyc_cnt);
            chk("result_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("result_value", int'(bus.m_data), exp_q.pop_front());
        end
    end

    initial begin
        int stall;
        stall = 0;
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!bp_mode) begin
                bus.m_ready = 1'b1;
                stall = 0;
            end else if (bus.m_valid && !bus.m_ready) begin
                if (stall >= 10) bus.m_ready = 1'b1;
                else stall++;
            end else begin
                bus.m_ready = 1'b0;
                stall = 0;
            end
        end
    end

    task automatic feed(input int n, input bit bp, output int got);
        bit sv;
        int cyc;
        sv = 1'b0; cyc = 0; got = 0;
        while (got < n && cyc < 4000) begin
            sv = bp ? ~sv : 1'b1;
            bus.s_valid = sv;
            bus.s_data  = stim[got];
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) got++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic start_layer(input int w, input int d, input int off, input int b);
        @(posedge clk); #1;
        bus.cfg_width = w; bus.cfg_depth = d;
        bus.cfg_input_offset = off; bus.cfg_bias = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.cfg_width = 0; bus.cfg_depth = 0;
        bus.cfg_input_offset = 32'h55; bus.cfg_bias = 32'h7fff;
    endtask

    task automatic run_layer(input string tag, input int w, input int d, input int off,
                             input int b, input bit bp);
        int got, cyc;
        bit done_seen;
        bp_mode = bp;
        beats_cnt = 0;
        hs_q.delete();
        start_layer(w, d, off, b);
        chk({tag, "_busy"}, int'(bus.busy), 1);
        feed(stim.size(), bp, got);
        chk({tag, "_beats_fed"}, got, stim.size());
        done_seen = 1'b0; cyc = 0;
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
            cyc++;
        end
        chk({tag, "_done_seen"}, int'(done_seen), 1);
        chk({tag, "_busy_at_done"}, int'(bus.busy), 0);
        chk({tag, "_err"}, int'(bus.err), 0);
        chk({tag, "_beats_accepted"}, beats_cnt, stim.size());
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(bus.done), 0);
        chk({tag, "_all_results"}, exp_q.size(), 0);
        bp_mode = 1'b0;
    endtask

    task automatic run_err(input string tag, input int w, input int d);
        start_layer(w, d, 0, 0);
        chk({tag, "_c1_done"}, int'(bus.done), 0);
        chk({tag, "_c1_busy"}, int'(bus.busy), 1);
        chk({tag, "_c1_cmd"}, int'(bus.cfu_cmd), 127);
        @(posedge clk); #1;
        chk({tag, "_c2_done"}, int'(bus.done), 1);
        chk({tag, "_c2_err"}, int'(bus.err), 1);
        chk({tag, "_c2_busy"}, int'(bus.busy), 0);
        chk({tag, "_c2_cmd"}, int'(bus.cfu_cmd), 127);
        @(posedge clk); #1;
        chk({tag, "_c3_done"}, int'(bus.done), 0);
        chk({tag, "_c3_err"}, int'(bus.err), 1);
        chk({tag, "_c3_cmd"}, int'(bus.cfu_cmd), 127);
    endtask

    task automatic stim_scenario_a();
        stim.delete();
        for (int k = 0; k < 8; k++) stim.push_back((k == 3) ? 8'd2 : 8'd0);
        stim.push_back(8'd5);
    endtask

    task automatic stim_scenario_b();
        stim.delete();
        for (int k = 0; k < 16; k++) stim.push_back(8'd1);
        for (int x = 1; x <= 8; x++) stim.push_back(8'(x));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd"},     int'(bus.cfu_cmd), 127);
        chk({tag, "_inp0"},    int'(bus.cfu_inp0), 0);
        chk({tag, "_inp1"},    int'(bus.cfu_inp1), 0);
        chk({tag, "_busy"},    int'(bus.busy), 0);
        chk({tag, "_done"},    int'(bus.done), 0);
        chk({tag, "_err"},     int'(bus.err), 0);
        chk({tag, "_s_ready"}, int'(bus.s_ready), 0);
        chk({tag, "_m_valid"}, int'(bus.m_valid), 0);
        chk({tag, "_m_data"},  int'(bus.m_data), 0);
    endtask

    initial begin
        int got;
        reset = 1'b1;
        bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'd0;
        bus.cfg_width = 0; bus.cfg_depth = 0; bus.cfg_input_offset = 0; bus.cfg_bias = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // single tap hit: 10 + 2*(5+1)
        stim_scenario_a();
        exp_q.push_back(22);
        run_layer("a", 1, 1, 1, 10, 1'b0);

        // every window covers the whole 4x2 input: 1+..+8
        stim_scenario_b();
        repeat (4) exp_q.push_back(36);
        run_layer("b", 4, 2, 0, 0, 1'b0);
        chk("b_result_count", hs_q.size(), 4);
        for (int i = 1; i < hs_q.size(); i++) chk("b_gap", hs_q[i] - hs_q[i-1], 5);

        repeat (4) exp_q.push_back(36);
        run_layer("bp", 4, 2, 0, 0, 1'b1);
        chk("bp_result_count", hs_q.size(), 4);

        // kernel k3c0=1, k4c1=2; input x0={1,2}, x1={3,4}: out0=1+2*4, out1=3
        stim.delete();
        for (int k = 0; k < 16; k++) stim.push_back((k == 6) ? 8'd1 : ((k == 9) ? 8'd2 : 8'd0));
        for (int x = 1; x <= 4; x++) stim.push_back(8'(x));
        exp_q.push_back(9);
        exp_q.push_back(3);
        run_layer("layout", 2, 2, 0, 0, 1'b0);

        run_err("err_w0", 0, 1);
        run_err("err_d129", 4, 129);
        run_err("err_w1025", 1025, 1);

        stim_scenario_b();
        start_layer(4, 2, 0, 0);
        feed(19, 1'b0, got);
        chk("abort_fed", got, 19);
        chk("abort_pre_cmd", int'(bus.cfu_cmd), 10);
        chk("abort_pre_inp0", int'(bus.cfu_inp0), 2);
        chk("abort_pre_s_ready", int'(bus.s_ready), 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("abort_no_results", exp_q.size(), 0);

        stim_scenario_a();
        exp_q.push_back(22);
        run_layer("rerun", 1, 1, 1, 10, 1'b0);

        // -30 + 2*5 = -20 before clamping
        stim_scenario_a();
`ifdef CONV1D_SEQ_RELU_EN
        exp_q.push_back(0);
`else
        exp_q.push_back(-20);
`endif
        run_layer("neg", 1, 1, 0, -30, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv1d_cmd_sequencer.md
Name: conv1d_cmd_sequencer

Overview:
Initiator-side driver for the conv1d CFU command interface. It sits between a byte-stream source/result sink and the conv1d CFU, and takes one start request per layer. For each layer it clears the CFU, writes the parameters, streams kernel bytes then input bytes into the CFU buffers, and runs a per-output-position compute/readback loop. Each 32-bit accumulator is emitted on a valid/ready result stream.

Parameters:
MAX_WIDTH, 1024, largest legal input/output width (matches CFU buffer depth)
MAX_DEPTH, 128, largest legal input channel count
KERNEL_LENGTH, 8, taps per channel
ORIGIN_OFFSET, 3, in_x_origin = out_x - ORIGIN_OFFSET

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle layer request; sampled only in IDLE
cfg_width  in  32  input/output width for the layer
cfg_depth  in  32  input channel count
cfg_input_offset  in  32  signed, forwarded via cmd 20
cfg_bias  in  32  signed, forwarded via cmd 27
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at layer end
err  out  1  sticky until next accepted start; set on illegal cfg
s_valid  in  1  byte stream valid
s_ready  out  1  byte stream ready
s_data  in  8  kernel bytes (KERNEL_LENGTH*depth) then input bytes (width*depth), index order
m_valid  out  1  result valid
m_ready  in  1  result ready
m_data  out  32  signed accumulator for out_x, ascending
cfu_cmd  out  7  CFU command, registered
cfu_inp0  out  32  CFU address operand, registered
cfu_inp1  out  32  CFU value operand, registered
cfu_ret  in  32  CFU response; valid the cycle after the issuing command

Behaviour:
- Reset values: cfu_cmd=CMD_NOP (127), cfu_inp0=cfu_inp1=0, busy=done=err=0, s_ready=0, m_valid=0, m_data=0. Reset mid-layer aborts to IDLE immediately and emits no done.
- Every cycle not issuing a real command drives CMD_NOP. Each real command is held exactly one cycle.
- States: IDLE, CHECK, CLEAR, PARAM, LOAD_W, LOAD_X, ORIGIN, COMPUTE, FETCH, CAPTURE, EMIT, DONE.
- IDLE -> CHECK on start. cfg_* are latched, busy=1, err=0.
- CHECK:
  - cfg_width in [1,MAX_WIDTH] and cfg_depth in [1,MAX_DEPTH] -> CLEAR.
  - Otherwise err=1 -> DONE. No CFU command is issued.
- CLEAR: issue cmd 0 (one cycle).
- PARAM: four consecutive cycles issuing cmd 20 (input_offset), 25 (width), 26 (depth), 27 (bias), with the value on cfu_inp1.
- LOAD_W: s_ready=1. Each beat with s_valid&&s_ready issues cmd 11 with inp0=index, inp1={24'b0,s_data}. Index runs 0..KERNEL_LENGTH*depth-1. After the last beat -> LOAD_X.
- LOAD_X: same handshake with cmd 10, index 0..width*depth-1, then -> ORIGIN with out_x=0.
- A beat is accepted only in the cycle it is issued. If s_valid is low, the cycle issues NOP and the index holds.
- s_ready is 0 in every state other than LOAD_W and LOAD_X.
- Per-output loop:
  - ORIGIN issues cmd 42, inp1 = out_x - ORIGIN_OFFSET (signed 32-bit).
  - COMPUTE issues cmd 41.
  - FETCH issues cmd 43.
  - CAPTURE issues NOP and latches m_data <= cfu_ret.
  - EMIT: m_valid=1, m_data stable until m_ready. On handshake, out_x+1: if out_x==width-1 -> DONE, else -> ORIGIN.
- Steady-state throughput: 5 cycles per output when m_ready is held high.
- DONE: done=1 for one cycle, busy=0, -> IDLE. start asserted in DONE is ignored.
- start while busy is ignored. cfg changes while busy have no effect.
- Index counters are 17 bits (max 1024*128). Index and out_x comparisons are unsigned.

Optional Feature:
CONV1D_SEQ_RELU_EN:
- Defined: CAPTURE latches max(cfu_ret, 0), signed compare.
- Undefined: raw cfu_ret is passed through.
- Timing is identical in both builds.

Decomposition:
Package conv1d_seq_pkg:
- CMD_* localparams (RESET=0, WR_INPUT=10, WR_KERNEL=11, SET_OFFSET=20, SET_WIDTH=25, SET_DEPTH=26, SET_BIAS=27, COMPUTE=41, SET_ORIGIN=42, READ_ACC=43, NOP=127).
- State enum.
One natural sub-module: conv1d_seq_cmd_reg, which is the registered cmd/inp0/inp1 driver, defaulting to NOP when no issue request is present.

Test Plan:
- width=1, depth=1, offset=1, bias=10; kernel bytes {0,0,0,2,0,0,0,0}; input {5}; bench instantiates the real CFU -> one result 22, then done pulse; exactly 8+1 stream beats accepted.
- width=4, depth=2, all kernel bytes=1, input bytes 1..8, offset=0, bias=0 -> results 36,36,36,36 (all taps in range): sums 1..8; repeated pattern, no gaps.
- Backpressure: m_ready low 10 cycles at each result and s_valid toggled every other cycle -> identical values as the unstalled run; m_data stable while m_valid&&!m_ready.
- cfg_width=0, or cfg_depth=129 -> err=1, done pulse 2 cycles after start, cfu_cmd stays 127 throughout.
- Reset asserted during LOAD_X -> all outputs at reset values the same cycle. A new start afterwards completes the first scenario correctly (22).
- CONV1D_SEQ_RELU_EN build: first scenario with bias=-30 -> result 0 (raw -20); without the macro -> -20.
